// File: rtl/spi_nor_pkg.sv
// Shared opcodes, controller states and status helper for the SPI NOR flash model.
package spi_nor_pkg;

    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RDATA,
        WDATA,
        STAT,
        IGNORE
    } state_e;

    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear and enable.
module counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/flopen.sv
// Resettable register with load enable.
module flopen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/spi_nor_edge.sv
// Two-flop synchroniser for SCLK/CS/MOSI plus sample/shift and CS edge pulses.
module spi_nor_edge #(
    parameter int CLK_POL = 0,
    parameter int CLK_PHA = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic sample_o,
    output logic shift_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic mosi_o
);

    localparam logic POL = (CLK_POL != 0);
    localparam logic PHA = (CLK_PHA != 0);

    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_rise, sclk_fall, lead, trail;

    // Reset to the idle bus levels so no spurious edge is seen on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= {2{POL}};
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= POL;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_i};
            cs_sync_q   <= {cs_sync_q[0], cs_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    assign sclk_rise = sclk_sync_q[1] && !sclk_prev_q;
    assign sclk_fall = !sclk_sync_q[1] && sclk_prev_q;
    assign lead      = POL ? sclk_fall : sclk_rise;
    assign trail     = POL ? sclk_rise : sclk_fall;
    assign sample_o  = PHA ? trail : lead;
    assign shift_o   = PHA ? lead : trail;
    assign cs_fall_o = !cs_sync_q[1] && cs_prev_q;
    assign cs_rise_o = cs_sync_q[1] && !cs_prev_q;
    assign mosi_o    = mosi_sync_q[1];

endmodule

// File: rtl/spi_nor_model.sv
// SPI NOR flash slave model: READ, PP, WREN, WRDI, RDSR over a byte array memory.
module spi_nor_model #(
    parameter int CLK_POL    = 0,
    parameter int CLK_PHA    = 0,
    parameter int ADDR_BYTES = 3,
    parameter int DEPTH      = 4096,
    parameter int PAGE_SIZE  = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO,
    output logic WEL
);
    import spi_nor_pkg::*;

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
    localparam logic [1:0]    LAST_AB   = 2'(ADDR_BYTES - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, addr_sh;
    logic          wel_q, wel_d, is_rd_q, is_rd_d, wrote_q, wrote_d, wr_pend_q, wr_pend_d;
    logic          sample, shift_e, cs_fall, cs_rise, mosi_s;
    logic          smp, byte_done, out_ld, out_en;
    logic [2:0]    bit_cnt;
    logic [1:0]    ab_cnt;
    logic [7:0]    sr_in_q, sr_out_q, in_byte, out_val, out_nxt;
    logic [7:0]    mem_q [DEPTH] = '{default: 8'hFF};

    spi_nor_edge #(.CLK_POL(CLK_POL), .CLK_PHA(CLK_PHA)) u_edge (
        .clk(clk), .reset(reset), .sclk_i(SCLK), .cs_i(CS), .mosi_i(MOSI),
        .sample_o(sample), .shift_o(shift_e), .cs_fall_o(cs_fall), .cs_rise_o(cs_rise),
        .mosi_o(mosi_s)
    );

    assign smp       = sample && (state_q != IDLE);
    assign byte_done = smp && (bit_cnt == 3'd7);
    assign in_byte   = {sr_in_q[6:0], mosi_s};
    assign addr_sh   = {addr_q[AW-2:0], mosi_s};

    counter #(.W(3)) u_bit_cnt (
        .clk(clk), .reset(reset), .clr_i(state_q == IDLE || cs_rise), .en_i(smp), .q_o(bit_cnt)
    );

    counter #(.W(2)) u_ab_cnt (
        .clk(clk), .reset(reset), .clr_i(state_q != ADDR), .en_i(byte_done && state_q == ADDR),
        .q_o(ab_cnt)
    );

    flopen #(.W(8)) u_sr_in (
        .clk(clk), .reset(reset), .en_i(smp), .d_i(in_byte), .q_o(sr_in_q)
    );

    // No shift on the first shift edge of a byte, so a freshly loaded bit 7 stays on MISO.
    assign out_en  = out_ld || (shift_e && bit_cnt != 3'd0 && (state_q == RDATA || state_q == STAT));
    assign out_nxt = out_ld ? out_val : {sr_out_q[6:0], 1'b0};

    flopen #(.W(8)) u_sr_out (
        .clk(clk), .reset(reset), .en_i(out_en), .d_i(out_nxt), .q_o(sr_out_q)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wel_d     = wel_q;
        is_rd_d   = is_rd_q;
        wrote_d   = wrote_q;
        wr_pend_d = 1'b0;
        out_ld    = 1'b0;
        out_val   = '0;
        case (state_q)
            IDLE: begin
                wrote_d = 1'b0;
                if (cs_fall) state_d = CMD;
            end
            CMD: if (byte_done) begin
                case (in_byte)
                    OP_READ: begin state_d = ADDR; is_rd_d = 1'b1; addr_d = '0; end
                    OP_PP:   begin state_d = wel_q ? ADDR : IGNORE; is_rd_d = 1'b0; addr_d = '0; end
                    OP_WREN: begin wel_d = 1'b1; state_d = IGNORE; end
                    OP_WRDI: begin wel_d = 1'b0; state_d = IGNORE; end
                    OP_RDSR: begin state_d = STAT; out_ld = 1'b1; out_val = status_byte(wel_q); end
                    default: state_d = IGNORE;
                endcase
            end
            ADDR: if (smp) begin
                addr_d = addr_sh;
                if (byte_done && ab_cnt == LAST_AB) begin
                    if (is_rd_q) begin
                        state_d = RDATA;
                        out_ld  = 1'b1;
                        out_val = mem_q[addr_sh];
                        addr_d  = addr_sh + ADDR_ONE;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            RDATA: if (byte_done) begin
                out_ld  = 1'b1;
                out_val = mem_q[addr_q];
                addr_d  = addr_q + ADDR_ONE;
            end
            WDATA: if (byte_done) begin
                wr_pend_d = 1'b1;
                wrote_d   = 1'b1;
            end
            STAT: if (byte_done) begin
                out_ld  = 1'b1;
                out_val = status_byte(wel_q);
            end
            default: ;
        endcase
        // Program address advances within its page only, after the byte lands.
        if (wr_pend_q) addr_d = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_ONE) & PAGE_MASK);
        if (cs_rise && state_q != IDLE) begin
            state_d = IDLE;
            if (wrote_d) wel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wel_q     <= 1'b0;
            is_rd_q   <= 1'b0;
            wrote_q   <= 1'b0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wel_q     <= wel_d;
            is_rd_q   <= is_rd_d;
            wrote_q   <= wrote_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend_q && !reset) mem_q[addr_q] <= sr_in_q;
    end

    assign MISO = (state_q == RDATA || state_q == STAT) && sr_out_q[7];
    assign WEL  = wel_q;

endmodule

// File: doc/spi_nor_model.md
SPI_NOR_MODEL -- requirements
Module: spi_nor_model

Interface
REQ-001 SHALL have parameter CLK_POL, default 0, SCLK idle level.
REQ-002 SHALL have parameter CLK_PHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have parameter ADDR_BYTES, default 3, address bytes after opcode (1..4).
REQ-004 SHALL have parameter DEPTH, default 4096, memory bytes (power of 2).
REQ-005 SHALL have parameter PAGE_SIZE, default 256, program page bytes (power of 2, at most DEPTH).
REQ-006 SHALL have one clock and a synchronous active-high reset: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port SCLK  in  1  SPI clock, asynchronous to clk.
REQ-008 SHALL have port CS  in  1  chip select, active-low.
REQ-009 SHALL have port MOSI  in  1  serial data in, MSB first.
REQ-010 SHALL have port MISO  out  1  serial data out, MSB first.
REQ-011 SHALL have port WEL  out  1  write-enable latch, for observation.

Function
REQ-012 SHALL register SCLK, CS and MOSI through 2 flops on clk; all behaviour keys off the registered values; SCLK frequency at most clk/4.
REQ-013 SHALL derive sample and shift edges from the registered SCLK edge, CLK_POL and CLK_PHA; MISO changes only on shift edges or on the cycle a byte is loaded.
REQ-014 SHALL implement states IDLE, CMD, ADDR, RDATA, WDATA, STAT, IGNORE; IDLE->CMD on registered CS falling edge.
REQ-015 CMD SHALL shift 8 bits and then decode the opcode: 0x03 READ->ADDR, 0x02 PP->ADDR if WEL else IGNORE, 0x06 WREN sets WEL->IGNORE, 0x04 WRDI clears WEL->IGNORE, 0x05 RDSR->STAT, other->IGNORE.
REQ-016 ADDR SHALL shift 8*ADDR_BYTES bits; address is taken modulo DEPTH; then READ->RDATA or PP->WDATA.
REQ-017 RDATA SHALL load mem[addr] into the shift register on entry and after every 8th bit, incrementing addr modulo DEPTH, for unbounded streaming.
REQ-018 For CLK_PHA=0, bit 7 of each read byte SHALL be on MISO before the first sample edge of that byte.
REQ-019 WDATA SHALL write each completed byte to mem[addr] one clk after its 8th sample edge, then increment only the low log2(PAGE_SIZE) address bits (page wrap).
REQ-020 STAT SHALL shift out status {6'b0, WEL, 1'b0} repeatedly until CS rises.
REQ-021 CS rising in any state SHALL return to IDLE next cycle, discard any partial byte and drive MISO 0.
REQ-022 WEL SHALL clear on that CS rise if at least one PP byte was written.
REQ-023 MISO SHALL be 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
REQ-024 If a CS rise and an 8th sample edge occur in the same registered cycle, the byte SHALL be completed (written or counted) before returning to IDLE.

Reset
REQ-025 Reset SHALL force IDLE, bit count 0, address 0, shift registers 0, WEL 0 and MISO 0, including mid-transaction.
REQ-026 Memory SHALL be initialised to 0xFF at time zero only and SHALL NOT be altered by reset.

Structure
REQ-027 Opcode constants and the state enum SHALL live in shared package spi_nor_pkg.
REQ-028 Synchroniser and edge detection SHALL be one sub-module, spi_nor_edge, reused by the SPI controller bench.
REQ-029 Bit and byte counters SHALL use the existing counter primitive; shift registers SHALL use flopen.

Verification
REQ-030 Mode 0, READ 0x03 addr 0x000010 on fresh memory -> MISO bytes 0xFF 0xFF, WEL=0.
REQ-031 Mode 0: WREN; PP addr 0x0000FE with data 0xA1 0xB2 0xC3 -> mem[0xFE]=0xA1, mem[0xFF]=0xB2, mem[0x00]=0xC3 (page wrap), WEL=0 after CS rises.
REQ-032 Each mode CLK_POL/CLK_PHA in {00, 01, 10, 11}: PP without WREN -> memory unchanged; RDSR -> 0x00; WREN then RDSR -> 0x02.
REQ-033 READ at address DEPTH-1 for 2 bytes -> mem[DEPTH-1] then mem[0].
REQ-034 CS rises after 4 bits of a PP data byte -> no write; next READ returns the prior contents.
REQ-035 Reset asserted mid-READ -> MISO=0 and state IDLE next cycle; the following READ returns correct data.
